svm_feat_loader: RTL

- Upstream feeder for the SVM classifier stage.
- Accepts one raw sensor sample per handshake and normalizes it per dimension as (x - offset[d]) * scale[d] in Q8.8.
- Assembles DIMS normalized samples into a parallel feature vector and holds it stable until the classifier side takes it.
- Converts the serial sensor-front-end stream into the `din[DIMS]` array the classifier registers.

---
 rtl/svm_feat_loader_pkg.sv | 49 ++++
 rtl/svm_feat_loader_norm.sv | 68 ++++++
 rtl/svm_feat_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/svm_feat_loader_pkg.sv
// ---------------------------------------------------------------------------
// svm_pkg
//
// Shared definitions for the SVM feature loader and its normalization
// datapath. The sizes here must agree with the downstream SVM classifier.
//
// Contents:
//   DIMS      - feature count per frame
//   W         - sample / feature width in bits (signed two's complement)
//   FRAC      - fractional bits of the per-dimension scale (Q(W-FRAC).FRAC)
//   CLASSES   - class count of the downstream classifier
//   IDX_W     - width of the dimension index
//   feat_t    - one sample / feature word
//   idx_t     - dimension index
//   ldr_state_e - loader FSM states (COLLECT, FULL)
//   next_idx() - dimension index increment helper
// ---------------------------------------------------------------------------
package svm_pkg;

    localparam int DIMS    = 21;
    localparam int W       = 16;
    localparam int FRAC    = 8;
    localparam int CLASSES = 4;
    localparam int IDX_W   = $clog2(DIMS);

    typedef logic [W-1:0]     feat_t;
    typedef logic [IDX_W-1:0] idx_t;

    // COLLECT gathers samples, FULL holds the finished vector for the consumer
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } ldr_state_e;

    localparam idx_t LAST_IDX = idx_t'(DIMS - 1);

    // Advance the dimension index; the last dimension wraps back to zero so
    // the index can never leave the 0..DIMS-1 range.
    function automatic idx_t next_idx(input idx_t cur);
        idx_t nxt;
        if (cur == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = cur + idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/svm_feat_loader_norm.sv
// ---------------------------------------------------------------------------
// feat_norm
//
// Purely combinational per-sample normalization:
//     y = ((x - offset) * scale) >>> FRAC
// with the subtraction done at W+1 bits and the product at 2W+1 bits so no
// intermediate overflow is possible. The shift is arithmetic, so the result
// is floored toward minus infinity.
//
// Configuration macro: SVM_FEAT_SAT_EN
//   defined   - result is clamped to the signed W-bit range
//   undefined - result is truncated to its W LSBs (wraps)
//
// Ports:
//   x       in  feat_t  raw sample, signed
//   offset  in  feat_t  offset for this dimension, signed
//   scale   in  feat_t  Q(W-FRAC).FRAC scale for this dimension, signed
//   y       out feat_t  normalized feature
// ---------------------------------------------------------------------------
module feat_norm
    import svm_pkg::*;
(
    input  feat_t x,
    input  feat_t offset,
    input  feat_t scale,
    output feat_t y
);

    localparam int PW = 2 * W + 1;

    logic signed [W:0]    diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] res;

    // Widen both operands by one sign bit before subtracting so that the
    // full range of (x - offset) is representable, then multiply at full
    // product width and drop the fractional bits of the scale.
    always_comb begin
        diff = $signed({x[W-1], x}) - $signed({offset[W-1], offset});
        prod = PW'(diff) * PW'($signed(scale));
        res  = prod >>> FRAC;
    end

`ifdef SVM_FEAT_SAT_EN
    logic overflow;

    // The result fits in W signed bits exactly when every bit from the W-1
    // position upward equals the sign bit; otherwise clamp toward the sign.
    always_comb begin
        overflow = (|res[PW-1:W-1]) & ~(&res[PW-1:W-1]);
        if (overflow) begin
            y = res[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = res[W-1:0];
        end
    end
`else
    logic unused_res_hi;

    // Wrapping build: only the low W bits survive, the upper product bits
    // are intentionally discarded.
    always_comb begin
        y             = res[W-1:0];
        unused_res_hi = ^res[PW-1:W];
    end
`endif

endmodule

// File: rtl/svm_feat_loader.sv
// ---------------------------------------------------------------------------
// svm_feat_loader
//
// Upstream feeder for the SVM classifier. Accepts one raw sensor sample per
// valid/ready handshake, normalizes it for its dimension through feat_norm,
// and stores it into a DIMS-wide parallel feature vector. Once the last
// dimension is stored the vector is presented on f_data_o/f_valid_o and held
// stable until the consumer takes it (or the frame is cleared).
//
// Configuration macro: SVM_FEAT_SAT_EN (saturating normalization, see
// feat_norm). Default build wraps.
//
// Ports:
//   clk_i      in   1            clock
//   rstn_i     in   1            asynchronous active-low reset
//   s_valid_i  in   1            sample valid
//   s_ready_o  out  1            loader can accept a sample
//   s_data_i   in   W            raw sample, signed
//   offsets_i  in   W x DIMS     per-dimension offset, signed
//   scales_i   in   W x DIMS     per-dimension Q8.8 scale, signed
//   clear_i    in   1            synchronous frame abort
//   f_valid_o  out  1            feature vector complete
//   f_ready_i  in   1            consumer accepts the vector
//   f_data_o   out  W x DIMS     normalized feature vector
//   idx_o      out  IDX_W        index of the next dimension to fill
//
// Reset assertion is asynchronous; the deassertion edge is expected to be
// synchronized to clk_i by the system reset controller.
// ---------------------------------------------------------------------------
module svm_feat_loader
    import svm_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  feat_t               s_data_i,
    input  feat_t [DIMS-1:0]    offsets_i,
    input  feat_t [DIMS-1:0]    scales_i,
    input  logic                clear_i,
    output logic                f_valid_o,
    input  logic                f_ready_i,
    output feat_t [DIMS-1:0]    f_data_o,
    output idx_t                idx_o
);

    ldr_state_e state;
    idx_t       idx;
    feat_t      norm_feat;
    logic       s_fire;

    // Handshake flags follow directly from the state, so the sample side is
    // never ready in the same cycle the vector is being handed off.
    assign s_ready_o = (state == COLLECT);
    assign f_valid_o = (state == FULL);
    assign idx_o     = idx;

    // A clear in the same cycle as a valid sample drops the sample.
    assign s_fire = s_valid_i & s_ready_o & ~clear_i;

    feat_norm u_norm (
        .x      (s_data_i),
        .offset (offsets_i[idx]),
        .scale  (scales_i[idx]),
        .y      (norm_feat)
    );

    // Frame sequencing: walk the dimension index while collecting, switch to
    // FULL on the last dimension, and return to COLLECT when the consumer
    // takes the vector or the frame is aborted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (clear_i) begin
                        idx <= '0;
                    end else if (s_valid_i) begin
                        idx <= next_idx(idx);
                        if (idx == LAST_IDX) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (clear_i || f_ready_i) begin
                        state <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Feature storage: each accepted sample lands in its dimension slot.
    // Entries are left untouched by clear so only reset zeroes them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            f_data_o <= '0;
        end else if (s_fire) begin
            f_data_o[idx] <= norm_feat;
        end
    end

endmodule
